// File: rtl/demultiplex_pkg.sv
// rtl/demultiplex_pkg.sv - shared types and helpers for the tagged stream demultiplexer
package demultiplex_pkg;

    localparam int MAX_BEAT = 64;

    // SLOT_ONE doubles as FULL when the slot holds a single entry.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_ONE   = 2'd1,
        SLOT_TWO   = 2'd2
    } slot_state_e;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_BEAT-1:0] beat_adr(input logic [MAX_BEAT-1:0] beat, input int w);
        return beat >> w;
    endfunction

    function automatic logic [MAX_BEAT-1:0] beat_dat(input logic [MAX_BEAT-1:0] beat, input int w);
        return beat & ((MAX_BEAT'(1) << w) - MAX_BEAT'(1));
    endfunction

endpackage

// File: rtl/demultiplex_slot.sv
// rtl/demultiplex_slot.sv - per-output register slot, or 2-entry skid FIFO under DEMULTIPLEX_SKID_EN
module demultiplex_slot
    import demultiplex_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] dat,
    output logic         full,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic         fire;

    assign m_valid = (state_q != SLOT_EMPTY);
    assign m_data  = head_q;
    assign fire    = m_valid & m_ready;

`ifdef DEMULTIPLEX_SKID_EN
    logic [W-1:0] tail_q, tail_d;

    // Only the registered TWO state blocks input, so ready never sees m_ready.
    assign full = (state_q == SLOT_TWO);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_ONE;
                    head_d  = dat;
                end
            end
            SLOT_ONE: begin
                if (fire && load) begin
                    head_d = dat;
                end else if (fire) begin
                    state_d = SLOT_EMPTY;
                end else if (load) begin
                    state_d = SLOT_TWO;
                    tail_d  = dat;
                end
            end
            SLOT_TWO: begin
                if (fire) begin
                    state_d = SLOT_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end
`else
    assign full = (state_q == SLOT_ONE);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (load) begin
            state_d = SLOT_ONE;
            head_d  = dat;
        end else if (fire) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
        end
    end
`endif

endmodule

// File: rtl/demultiplex.sv
// rtl/demultiplex.sv - routes {adr, dat} beats to N output streams; DEMULTIPLEX_SKID_EN selects 2-deep slots
module demultiplex
    import demultiplex_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W+addr_width(N)-1:0]  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [N*W-1:0]              m_data,
    output logic [N-1:0]                m_valid,
    input  logic [N-1:0]                m_ready
);

    localparam int A = addr_width(N);

    logic [A-1:0] adr;
    logic [W-1:0] dat;
    logic [N-1:0] load;
    logic [N-1:0] slot_full;
    logic         sel_full;
    logic         ready_en_q;
    logic         in_fire;

    assign adr     = A'(beat_adr(MAX_BEAT'(s_data), W));
    assign dat     = W'(beat_dat(MAX_BEAT'(s_data), W));
    assign in_fire = s_valid & s_ready;

    // Holds s_ready low for one cycle after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

`ifdef DEMULTIPLEX_SKID_EN
    always_comb begin
        sel_full = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (adr == A'(k)) begin
                sel_full = slot_full[k];
            end
        end
    end

    assign s_ready = ready_en_q & ~rst & ~sel_full;
`else
    logic sel_ready;

    // Out-of-range adr keeps the defaults, so the beat is accepted and dropped.
    always_comb begin
        sel_full  = 1'b0;
        sel_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (adr == A'(k)) begin
                sel_full  = slot_full[k];
                sel_ready = m_ready[k];
            end
        end
    end

    assign s_ready = ready_en_q & ~rst & (~sel_full | sel_ready);
`endif

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign load[k] = in_fire & (adr == A'(k));

        demultiplex_slot #(.W(W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .dat     (dat),
            .full    (slot_full[k]),
            .m_valid (m_valid[k]),
            .m_ready (m_ready[k]),
            .m_data  (m_data[k*W +: W])
        );
    end

endmodule

// File: tb/tb_demultiplex.sv
// tb/tb_demultiplex.sv - scoreboard bench for demultiplex (W=16, N=4), either DEMULTIPLEX_SKID_EN build
`timescale 1ns/1ps
module tb_demultiplex;

    localparam int W = 16;
    localparam int N = 4;
    localparam int A = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [W+A-1:0] s_data;
    logic           s_valid;
    logic           s_ready;
    logic [N*W-1:0] m_data;
    logic [N-1:0]   m_valid;
    logic [N-1:0]   m_ready;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    logic rnd_ready = 1'b0;
    logic [W-1:0] exp_q [N][$];

    demultiplex #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every output handshake must match the head of that output's queue.
    logic [W-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                if (m_valid[k] === 1'b1 && m_ready[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_out%0d: got %0h expected no beat", k, m_data[k*W +: W]);
                    end else begin
                        mon_exp = exp_q[k].pop_front();
                        chk($sformatf("out%0d_data", k), 64'(m_data[k*W +: W]), 64'(mon_exp));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    // exp_imm: -1 skips the first-cycle s_ready check.
    task automatic send(input logic [A-1:0] a, input logic [W-1:0] d, input int exp_imm, input string name);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = {a, d};
        @(negedge clk);
        if (exp_imm >= 0) chk({name, "_ready"}, 64'(s_ready), 64'(exp_imm));
        while (s_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
            if (rnd_ready) m_ready = N'($urandom);
            @(negedge clk);
        end
        if (s_ready === 1'b1) begin
            exp_q[a].push_back(d);
            tick();
        end else begin
            n_total++;
            $display("FAIL %s_timeout: got s_ready=%0b expected 1 within 50 cycles", name, s_ready);
            s_valid = 1'b0;
        end
    endtask

    task automatic check_drained(input string name);
        for (int k = 0; k < N; k++) chk($sformatf("%s_left%0d", name, k), 64'(exp_q[k].size()), 64'd0);
    endtask

    logic [A-1:0] str_adr [10] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
    logic [W-1:0] str_dat [10] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                   16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int start;
        logic [N-1:0] any_valid;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = '1;
        repeat (3) tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        chk("release_s_ready", 64'(s_ready), 64'd0);
        tick();
        chk("post_release_s_ready", 64'(s_ready), 64'd1);

        any_valid = '0;
        repeat (20) begin
            tick();
            any_valid |= m_valid;
        end
        chk("idle_m_valid", 64'(any_valid), 64'd0);

        send(2'd2, 16'hBEEF, 1, "single");
        chk("single_m_valid", 64'(m_valid), 64'b0100);
        chk("single_m_data2", 64'(m_data[2*W +: W]), 64'hBEEF);
        idle(2);

        start = cyc;
        for (int i = 0; i < 10; i++) send(str_adr[i], str_dat[i], 1, $sformatf("stream%0d", i));
        chk("stream_cycles", 64'(cyc - start), 64'd10);
        idle(3);
        check_drained("stream");

        m_ready = 4'b1101;
        send(2'd1, 16'hA001, 1, "blk_a1");
`ifdef DEMULTIPLEX_SKID_EN
        send(2'd1, 16'hA002, 1, "blk_a2");
        send(2'd3, 16'hC003, 1, "blk_c3");
        chk("blk_m_valid", 64'(m_valid), 64'b1010);
        fork
            send(2'd1, 16'hA003, 0, "blk_a3");
            begin
                repeat (3) @(posedge clk);
                #2 m_ready = 4'b1111;
            end
        join
`else
        chk("blk_m_valid", 64'(m_valid), 64'b0010);
        fork
            send(2'd1, 16'hA002, 0, "blk_a2");
            begin
                repeat (3) @(posedge clk);
                #2 m_ready = 4'b1111;
            end
        join
        send(2'd3, 16'hC003, 1, "blk_c3");
`endif
        idle(4);
        check_drained("blk");

        send(2'd0, 16'hD001, 1, "refill_d1");
        send(2'd0, 16'hD002, 1, "refill_d2");
        chk("refill_m_valid", 64'(m_valid), 64'b0001);
        chk("refill_m_data0", 64'(m_data[W-1:0]), 64'hD002);
        idle(3);
        check_drained("refill");

        m_ready = 4'b0000;
        send(2'd0, 16'hE000, 1, "mid_e0");
        send(2'd3, 16'hE003, 1, "mid_e3");
        chk("mid_m_valid_full", 64'(m_valid), 64'b1001);
        s_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < N; k++) exp_q[k].delete();
        tick();
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data", 64'(m_data), 64'd0);
        rst = 1'b0;
        m_ready = 4'b1111;
        chk("mid_release_s_ready", 64'(s_ready), 64'd0);
        tick();
        chk("mid_post_release_s_ready", 64'(s_ready), 64'd1);

        rnd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            m_ready = N'($urandom);
            send(A'($urandom_range(0, N - 1)), W'($urandom), -1, $sformatf("rnd%0d", i));
        end
        rnd_ready = 1'b0;
        s_valid = 1'b0;
        m_ready = 4'b1111;
        idle(6);
        check_drained("rnd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
